// File: rtl/debounce_edge_counter.sv
// Synchronises and debounces a bouncing asynchronous level, emitting a clean
// level, one-cycle rise/fall pulses and a saturating count of rising edges.
module debounce_edge_counter #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             clr,
    output logic             out,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] evt_count
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_e;

    localparam logic [7:0]       DB_LAST = 8'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [7:0]       dbc_q, dbc_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] evt_q, evt_d;

    // Two-flop synchroniser; only s2_q feeds the debouncer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= in;
            s2_q <= s1_q;
        end
    end

    // State register with its qualification counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            dbc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            dbc_q   <= dbc_d;
        end
    end

    // Next-state logic: a candidate level must persist DB_CYCLES samples.
    always_comb begin
        state_d = state_q;
        dbc_d   = dbc_q;
        case (state_q)
            STABLE_LO: begin
                if (s2_q) begin
                    state_d = QUAL_HI;
                    dbc_d   = 8'd1;
                end else begin
                    dbc_d   = 8'd0;
                end
            end
            QUAL_HI: begin
                if (!s2_q) begin
                    state_d = STABLE_LO;
                    dbc_d   = 8'd0;
                end else if (dbc_q == DB_LAST) begin
                    state_d = STABLE_HI;
                    dbc_d   = 8'd0;
                end else begin
                    dbc_d   = dbc_q + 8'd1;
                end
            end
            STABLE_HI: begin
                if (!s2_q) begin
                    state_d = QUAL_LO;
                    dbc_d   = 8'd1;
                end else begin
                    dbc_d   = 8'd0;
                end
            end
            QUAL_LO: begin
                if (s2_q) begin
                    state_d = STABLE_HI;
                    dbc_d   = 8'd0;
                end else if (dbc_q == DB_LAST) begin
                    state_d = STABLE_LO;
                    dbc_d   = 8'd0;
                end else begin
                    dbc_d   = dbc_q + 8'd1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                dbc_d   = 8'd0;
            end
        endcase
    end

    // Output decode from the transition, so outputs land with the new state.
    always_comb begin
        out_d  = (state_d == STABLE_HI) || (state_d == QUAL_LO);
        busy_d = (dbc_d != 8'd0);
        rise_d = (state_q == QUAL_HI) && (state_d == STABLE_HI);
        fall_d = (state_q == QUAL_LO) && (state_d == STABLE_LO);
        if (clr) begin
            evt_d = {CNT_W{1'b0}};
        end else if (rise_q) begin
            evt_d = sat_inc(evt_q);
        end else begin
            evt_d = evt_q;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            busy_q <= 1'b0;
            evt_q  <= {CNT_W{1'b0}};
        end else begin
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            busy_q <= busy_d;
            evt_q  <= evt_d;
        end
    end

    assign out       = out_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign busy      = busy_q;
    assign evt_count = evt_q;

endmodule

// File: tb/tb_debounce_edge_counter.sv
// Scoreboard bench for debounce_edge_counter (DB_CYCLES=4, CNT_W=3).
module tb_debounce_edge_counter;

    localparam int DB    = 4;
    localparam int CW    = 3;
    localparam int EMAX  = 7;

    logic          clk;
    logic          rst_n;
    logic          din;
    logic          clr;
    logic          out;
    logic          rise;
    logic          fall;
    logic          busy;
    logic [CW-1:0] evt_count;

    int n_checks;
    int n_errors;
    int n_rise;
    int n_fall;
    logic busy_seen;
    logic [6:0] exp_q[$];

    debounce_edge_counter #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .clr       (clr),
        .out       (out),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy),
        .evt_count (evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: sample history is compared against the current level.
    initial begin
        logic m_s1, m_s2, samp, m_out, m_rise, m_fall;
        int   m_run, m_evt;
        m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_run = 0; m_evt = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
                m_run = 0; m_evt = 0;
            end else begin
                samp = m_s2;
                m_s2 = m_s1;
                m_s1 = din;
                if (clr) m_evt = 0;
                else if (m_rise && m_evt < EMAX) m_evt = m_evt + 1;
                m_rise = 1'b0;
                m_fall = 1'b0;
                if (samp != m_out) begin
                    m_run = m_run + 1;
                    if (m_run == DB) begin
                        m_out = ~m_out;
                        m_run = 0;
                        if (m_out) m_rise = 1'b1;
                        else       m_fall = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
            end
            exp_q.push_back({m_out, m_rise, m_fall, (m_run != 0), 3'(m_evt)});
        end
    end

    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("scoreboard", {25'd0, out, rise, fall, busy, evt_count}, {25'd0, e});
            end
        end
    end

    initial begin
        forever begin
            @(negedge rst_n);
            exp_q.delete();
        end
    end

    initial begin
        n_rise = 0; n_fall = 0; busy_seen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rise) n_rise++;
            if (fall) n_fall++;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic wait_rise(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rise) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_release();
        din = 1'b1;
        cycles(10);
        din = 1'b0;
        cycles(10);
    endtask

    initial begin
        int lat, r0, f0, e0;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; din = 1'b1; clr = 1'b0;

        // Reset held with in=1, then released mid-cycle.
        cycles(4);
        check_eq("rst_out", {31'd0, out}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_evt", {29'd0, evt_count}, 32'd0);
        din = 1'b0;
        #2 rst_n = 1'b1;
        cycles(3);
        check_eq("rel_out", {31'd0, out}, 32'd0);
        din = 1'b1;
        wait_rise(lat);
        check_eq("latency_rise", lat, 32'd6);
        check_eq("latency_out", {31'd0, out}, 32'd1);
        @(negedge clk);
        check_eq("evt_after_rise", {29'd0, evt_count}, 32'd1);

        // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted.
        din = 1'b0;
        cycles(10);
        r0 = n_rise; f0 = n_fall; e0 = int'(evt_count);
        busy_seen = 1'b0;
        din = 1'b1; cycles(3); din = 1'b0;
        cycles(10);
        check_eq("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check_eq("glitch_busy_clr", {31'd0, busy}, 32'd0);
        check_eq("glitch_out", {31'd0, out}, 32'd0);
        check_eq("glitch_rise", n_rise - r0, 32'd0);
        check_eq("glitch_evt", {29'd0, evt_count}, e0);
        din = 1'b1; cycles(4); din = 1'b0;
        cycles(15);
        check_eq("pulse4_rise", n_rise - r0, 32'd1);
        check_eq("pulse4_fall", n_fall - f0, 32'd1);

        // Bounce train then steady high.
        r0 = n_rise; f0 = n_fall; e0 = int'(evt_count);
        for (int i = 0; i < 8; i++) begin
            din = (i % 2 == 0);
            @(negedge clk);
        end
        din = 1'b1;
        cycles(12);
        check_eq("bounce_rise", n_rise - r0, 32'd1);
        check_eq("bounce_fall", n_fall - f0, 32'd0);
        check_eq("bounce_evt", {29'd0, evt_count}, e0 + 1);
        din = 1'b0;
        cycles(10);

        // Clear, then clear colliding with the 2->3 increment.
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check_eq("clr_evt", {29'd0, evt_count}, 32'd0);
        press_release();
        press_release();
        check_eq("pre_collide_evt", {29'd0, evt_count}, 32'd2);
        din = 1'b1;
        wait_rise(lat);
        check_eq("collide_latency", lat, 32'd6);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("collide_evt", {29'd0, evt_count}, 32'd0);
        din = 1'b0;
        cycles(10);
        press_release();
        check_eq("post_collide_evt", {29'd0, evt_count}, 32'd1);

        // Saturation at 7 over nine press/release cycles.
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        r0 = n_rise; f0 = n_fall;
        for (int i = 0; i < 9; i++) begin
            press_release();
            if (i == 6) check_eq("sat_at7", {29'd0, evt_count}, 32'd7);
        end
        check_eq("sat_hold", {29'd0, evt_count}, 32'd7);
        check_eq("sat_rises", n_rise - r0, 32'd9);
        check_eq("sat_falls", n_fall - f0, 32'd9);

        // Reset during QUAL_LO.
        din = 1'b1;
        cycles(10);
        f0 = n_fall; r0 = n_rise;
        din = 1'b0;
        cycles(3);
        check_eq("qlo_busy", {31'd0, busy}, 32'd1);
        check_eq("qlo_out", {31'd0, out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out", {31'd0, out}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        din = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_rise(lat);
        check_eq("midrst_latency", lat, 32'd6);
        cycles(3);
        check_eq("midrst_fall", n_fall - f0, 32'd0);
        check_eq("midrst_rise", n_rise - r0, 32'd1);
        check_eq("midrst_out_hi", {31'd0, out}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
